// File: rtl/rr_mux_arbiter_4x1.sv
// rr_mux_arbiter_4x1: round-robin arbiter driving a shared 4:1 data mux into a
// 1-deep registered output stage drained with out_valid/out_ready.
// Optional feature macro: ARB_BURST_EN (lets the previous winner keep priority
// for up to MAX_BURST consecutive loads). Default build is pure round robin.
module rr_mux_arbiter_4x1 #(
  parameter int BITS      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [BITS-1:0] in0,
  input  logic [BITS-1:0] in1,
  input  logic [BITS-1:0] in2,
  input  logic [BITS-1:0] in3,
  output logic [3:0]      grant,
  output logic [1:0]      sel,
  output logic [BITS-1:0] out,
  output logic            out_valid,
  input  logic            out_ready
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("rr_mux_arbiter_4x1: MAX_BURST must be in 1..255");
  end

  logic [BITS-1:0] out_q;
  logic [1:0]      sel_q;
  logic            vld_q;
  logic [1:0]      last_q;

  logic            can_load;
  logic            win_found;
  logic [1:0]      win_idx;
  logic            load;
  logic [BITS-1:0] mux_d;

`ifdef ARB_BURST_EN
  logic [7:0]      burst_cnt_q;
  logic            sticky_q;
  logic [7:0]      burst_cnt_d;
  logic            sticky_d;
`endif

  assign can_load = !vld_q || out_ready;
  assign load     = can_load && win_found;

  // Pick the winner: held burst owner first (if enabled), else scan from last+1.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = 2'd0;
`ifdef ARB_BURST_EN
    if (sticky_q && req[last_q]) begin
      win_found = 1'b1;
      win_idx   = last_q;
    end
`endif
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // One-hot grant, suppressed while in reset or when the stage cannot load.
  always_comb begin
    grant = 4'b0000;
    if (!rst && load) grant = 4'b0001 << win_idx;
  end

  // Shared datapath mux steered by the current winner.
  always_comb begin
    mux_d = in0;
    case (win_idx)
      2'd0: mux_d = in0;
      2'd1: mux_d = in1;
      2'd2: mux_d = in2;
      2'd3: mux_d = in3;
      default: mux_d = in0;
    endcase
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      sel_q  <= 2'd0;
      vld_q  <= 1'b0;
      last_q <= 2'd3;
    end else if (load) begin
      out_q  <= mux_d;
      sel_q  <= win_idx;
      vld_q  <= 1'b1;
      last_q <= win_idx;
    end else if (vld_q && out_ready) begin
      vld_q  <= 1'b0;
    end
  end

`ifdef ARB_BURST_EN
  // Burst bookkeeping: sticky_q marks that the last winner may repeat; burst_cnt_q
  // counts repeats so far. Hitting MAX_BURST-1 repeats ends the burst.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    sticky_d    = sticky_q;
    if (load) begin
      burst_cnt_d = (sticky_q && (win_idx == last_q)) ? burst_cnt_q + 8'd1 : 8'd0;
      if (burst_cnt_d == 8'(MAX_BURST - 1)) begin
        burst_cnt_d = 8'd0;
        sticky_d    = 1'b0;
      end else begin
        sticky_d    = 1'b1;
      end
    end
  end

  // Burst state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= 8'd0;
      sticky_q    <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      sticky_q    <= sticky_d;
    end
  end
`endif

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// Testbench for rr_mux_arbiter_4x1: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_rr_mux_arbiter_4x1;
  localparam int BITS = 4;
`ifdef ARB_BURST_EN
  localparam int MAXB = 2;
  localparam int MB   = MAXB;
`else
  localparam int MAXB = 4;
  localparam int MB   = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [BITS-1:0] in0, in1, in2, in3;
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic [BITS-1:0] dout;
  logic            out_valid;
  logic            out_ready;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int              m_last;
  bit              m_vld;
  logic [BITS-1:0] m_out;
  int              m_sel;
  bit              m_inb;   // current winner still inside its burst
  int              m_run;   // loads won so far in the current burst

  rr_mux_arbiter_4x1 #(.BITS(BITS), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant), .sel(sel), .out(dout),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] din(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  function automatic int exp_winner();
    if (rst || !(!m_vld || out_ready) || req == 4'b0) return -1;
    if (MB > 1 && m_inb && m_run < MB && req[m_last]) return m_last;
    for (int k = 1; k <= 4; k++)
      if (req[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    int w;
    w = exp_winner();
    return (w < 0) ? 4'b0 : 4'(1 << w);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input int w);
    if (rst) begin
      m_last = 3; m_vld = 0; m_out = '0; m_sel = 0; m_inb = 0; m_run = 0;
    end else if (w >= 0) begin
      if (m_inb && w == m_last) m_run = m_run + 1;
      else                      m_run = 1;
      m_inb  = (m_run < MB);
      m_out  = din(w);
      m_sel  = w;
      m_vld  = 1;
      m_last = w;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy, input logic rs);
    req = r; out_ready = rdy; rst = rs;
  endtask

  task automatic set_data(input logic [BITS-1:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  task automatic test_reset();
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    for (int c = 0; c < 2; c++) begin
      drive(4'hF, 1'b1, 1'b1);
      #1;
      total++;
      if (grant !== 4'b0) begin
        bad++; $display("FAIL reset_grant got=%b exp=0000", grant);
      end
      @(posedge clk); model_step(-1); #1;
      total++;
      if ({out_valid, sel, dout} !== {1'b0, 2'd0, 4'h0}) begin
        bad++; $display("FAIL reset_state got vld=%b sel=%0d out=%h exp 0/0/0", out_valid, sel, dout);
      end
    end
    drive(4'hF, 1'b1, 1'b0);
    #1;
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant got=%b exp=0001", grant);
    end
  endtask

  task automatic test_all_req();
    logic [3:0] gseq [5];
    logic [3:0] oseq [5];
    int w;
    gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    oseq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    drive(4'hF, 1'b1, 1'b1); @(posedge clk); model_step(-1); #1;
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    for (int c = 0; c < 5; c++) begin
      drive(4'hF, 1'b1, 1'b0);
      #1;
      total++;
      if (grant !== gseq[c] || grant !== exp_grant()) begin
        bad++; $display("FAIL all_req_grant[%0d] got=%b exp=%b", c, grant, gseq[c]);
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
      total++;
      if (out_valid !== 1'b1 || dout !== oseq[c]) begin
        bad++; $display("FAIL all_req_out[%0d] got vld=%b out=%h exp 1/%h", c, out_valid, dout, oseq[c]);
      end
    end
  endtask

  task automatic test_alternate();
    int w;
    drive(4'b0101, 1'b1, 1'b1); @(posedge clk); model_step(-1); #1;
    set_data(4'hA, 4'hB, 4'hC, 4'hD);
    for (int c = 0; c < 4; c++) begin
      drive(4'b0101, 1'b1, 1'b0);
      #1;
      total++;
      if ((grant & 4'b1010) !== 4'b0 || grant !== exp_grant()) begin
        bad++; $display("FAIL alt_grant[%0d] got=%b exp=%b", c, grant, exp_grant());
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
      total++;
      if (sel !== 2'((c % 2) * 2) || dout !== ((c % 2) ? 4'hC : 4'hA)) begin
        bad++; $display("FAIL alt_sel[%0d] got sel=%0d out=%h exp sel=%0d", c, sel, dout, (c % 2) * 2);
      end
    end
  endtask

  task automatic test_stall();
    int w;
    logic [1:0]      hs;
    logic [BITS-1:0] ho;
    drive(4'hF, 1'b0, 1'b1); @(posedge clk); model_step(-1); #1;
    set_data(4'h5, 4'h6, 4'h7, 4'h8);
    drive(4'hF, 1'b0, 1'b0); #1;
    w = exp_winner();
    @(posedge clk); model_step(w); #1;
    hs = sel; ho = dout;
    total++;
    if (out_valid !== 1'b1 || dout !== 4'h5) begin
      bad++; $display("FAIL stall_first_load got vld=%b out=%h exp 1/5", out_valid, dout);
    end
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, 1'b0, 1'b0); #1;
      total++;
      if (grant !== 4'b0) begin
        bad++; $display("FAIL stall_grant[%0d] got=%b exp=0000", c, grant);
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
      total++;
      if (out_valid !== 1'b1 || sel !== hs || dout !== ho || dout !== m_out) begin
        bad++; $display("FAIL stall_hold[%0d] got sel=%0d out=%h exp sel=%0d out=%h", c, sel, dout, hs, ho);
      end
    end
    drive(4'hF, 1'b1, 1'b0); #1;
    total++;
    if (grant !== 4'b0010) begin
      bad++; $display("FAIL stall_release_grant got=%b exp=0010", grant);
    end
    w = exp_winner();
    @(posedge clk); model_step(w); #1;
    total++;
    if (out_valid !== 1'b1 || dout !== 4'h6 || sel !== 2'd1) begin
      bad++; $display("FAIL stall_release_out got sel=%0d out=%h exp 1/6", sel, dout);
    end
  endtask

  task automatic test_mid_reset();
    int w;
    drive(4'b0100, 1'b0, 1'b0); #1;
    w = exp_winner();
    @(posedge clk); model_step(w); #1;
    drive(4'hF, 1'b0, 1'b1); #1;
    total++;
    if (grant !== 4'b0) begin
      bad++; $display("FAIL midrst_grant got=%b exp=0000", grant);
    end
    @(posedge clk); model_step(-1); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_vld got=%b exp=0", out_valid);
    end
    drive(4'hF, 1'b1, 1'b0); #1;
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL midrst_first got=%b exp=0001", grant);
    end
  endtask

  task automatic test_single();
    int w;
    drive(4'b1000, 1'b1, 1'b1); @(posedge clk); model_step(-1); #1;
    for (int c = 0; c < 4; c++) begin
      in3 = 4'(c + 9);
      drive(4'b1000, 1'b1, 1'b0); #1;
      total++;
      if (grant !== 4'b1000) begin
        bad++; $display("FAIL single_grant[%0d] got=%b exp=1000", c, grant);
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
      total++;
      if (out_valid !== 1'b1 || dout !== 4'(c + 9) || sel !== 2'd3) begin
        bad++; $display("FAIL single_out[%0d] got vld=%b out=%h exp 1/%h", c, out_valid, dout, 4'(c + 9));
      end
    end
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    int wseq [9];
    int w;
    wseq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    drive(4'hF, 1'b1, 1'b1); @(posedge clk); model_step(-1); #1;
    for (int c = 0; c < 9; c++) begin
      drive(4'hF, 1'b1, 1'b0); #1;
      total++;
      if (grant !== 4'(1 << wseq[c])) begin
        bad++; $display("FAIL burst_grant[%0d] got=%b exp=%b", c, grant, 4'(1 << wseq[c]));
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
    end
  endtask
`endif

  task automatic test_random();
    int w;
    logic [3:0] r;
    logic [3:0] g;
    r = 4'b0;
    for (int c = 0; c < 400; c++) begin
      // Requesters hold pending words until granted; idle ones may raise a new
      // request with fresh data, and a pending one occasionally withdraws.
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            r[i] = 1'b1;
            case (i)
              0: in0 = 4'($urandom);
              1: in1 = 4'($urandom);
              2: in2 = 4'($urandom);
              default: in3 = 4'($urandom);
            endcase
          end
        end else if ($urandom_range(15, 0) == 0) begin
          r[i] = 1'b0;
        end
      end
      drive(r, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(63, 0) == 0));
      #1;
      g = exp_grant();
      total++;
      if (grant !== g) begin
        bad++; $display("FAIL rand_grant[%0d] got=%b exp=%b", c, grant, g);
      end
      w = exp_winner();
      @(posedge clk); model_step(w); #1;
      r = r & ~g;
      total++;
      if ({out_valid, sel, dout} !== {m_vld, 2'(m_sel), m_out}) begin
        bad++; $display("FAIL rand_out[%0d] got vld=%b sel=%0d out=%h exp vld=%b sel=%0d out=%h",
                        c, out_valid, sel, dout, m_vld, m_sel, m_out);
      end
    end
  endtask

  initial begin
    m_last = 3; m_vld = 0; m_out = '0; m_sel = 0; m_inb = 0; m_run = 0;
    drive(4'b0, 1'b0, 1'b1);
    set_data('0, '0, '0, '0);
    test_reset();
    test_all_req();
    test_alternate();
    test_stall();
    test_mid_reset();
    test_single();
`ifdef ARB_BURST_EN
    test_burst();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
